fetch_unit: RTL

Instruction-fetch front end for the pipelined core. Generates the sequential PC, issues word reads to the instruction memory, and buffers returned instructions with their PCs in a small FIFO. The FIFO drains to decode over a valid/ready handshake. A redirect from execute (taken branch/jump) flushes the buffer, discards in-flight reads and restarts fetch at the target.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, defaults and the buffered fetch entry type for the fetch front end.
package fetch_unit_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0100_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Clears the byte-offset bits so fetch always stays word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, inst} entries between instruction memory and decode.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 push_entry,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  // Flush takes priority; the caller already masks push/pop during flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads back as zero until filled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC, one-cycle imem reads, credit-limited buffering.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] captured_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            credit;
  logic            pop;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = inflight && !redirect_valid;

  // An in-flight read already owns a slot; a pop this cycle frees one.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign credit    = occupancy < (CW+1)'(DEPTH);

  assign imem_req  = reset && !redirect_valid && credit;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      captured_pc <= '0;
      inflight    <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
      inflight <= 1'b0;
    end else if (imem_req) begin
      fetch_pc    <= fetch_pc + PC_STEP;
      captured_pc <= fetch_pc;
      inflight    <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  assign push_entry.pc   = captured_pc;
  assign push_entry.inst = imem_data;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign out_inst = head.inst;
  assign out_pc   = head.pc;

endmodule
